// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer
// Byte-stream front/back end for the array multiplier: collects operand A then
// operand B over a valid/ready input, holds them for the multiplier for
// MULT_LAT cycles, then returns the 16-bit product low byte first.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_LOAD_A  | waiting for operand A byte (in_ready=1)
//   ST_LOAD_B  | waiting for operand B byte (in_ready=1)
//   ST_MULT    | operands presented, op_valid=1, counting down latency
//   ST_SEND_LO | result[7:0] on dout, waiting for dout_ready
//   ST_SEND_HI | result[15:8] on dout with dout_last, waiting for dout_ready
module mult_operand_sequencer #(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic                 op_valid,
    input  logic [2*WIDTH-1:0]   prod,
    output logic [7:0]           dout,
    output logic                 dout_valid,
    output logic                 dout_last,
    input  logic                 dout_ready
);

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_MULT    = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_HI = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       res_hi_q, res_hi_d;
    logic [7:0]       dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;

    logic             in_xfer;
    logic             out_xfer;
    logic [15:0]      prod_ext;

    // Bits of data_in above WIDTH are intentionally ignored.
    logic             unused_data;
    assign unused_data = ^data_in;

    // in_ready decodes the state register only, so dout_ready never reaches it.
    assign in_ready   = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = dout_valid_q && dout_ready;

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_valid   = op_valid_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

    // Zero-extend the product to the 16-bit result regardless of WIDTH.
    always_comb begin
        prod_ext = '0;
        prod_ext[2*WIDTH-1:0] = prod;
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_valid_d   = op_valid_q;
        cnt_d        = cnt_q;
        res_hi_d     = res_hi_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;

        case (state_q)
            ST_LOAD_A: begin
                if (in_xfer) begin
                    op_a_d  = data_in[WIDTH-1:0];
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (in_xfer) begin
                    op_b_d     = data_in[WIDTH-1:0];
                    op_valid_d = 1'b1;
                    cnt_d      = 4'(MULT_LAT - 1);
                    state_d    = ST_MULT;
                end
            end
            ST_MULT: begin
                if (cnt_q == 4'd0) begin
                    res_hi_d     = prod_ext[15:8];
                    dout_d       = prod_ext[7:0];
                    dout_valid_d = 1'b1;
                    dout_last_d  = 1'b0;
                    op_valid_d   = 1'b0;
                    state_d      = ST_SEND_LO;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_SEND_LO: begin
                if (out_xfer) begin
                    dout_d      = res_hi_q;
                    dout_last_d = 1'b1;
                    state_d     = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (out_xfer) begin
                    dout_valid_d = 1'b0;
                    dout_last_d  = 1'b0;
                    state_d      = ST_LOAD_A;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_LOAD_A;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_valid_q   <= 1'b0;
            cnt_q        <= 4'd0;
            res_hi_q     <= 8'd0;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_valid_q   <= op_valid_d;
            cnt_q        <= cnt_d;
            res_hi_q     <= res_hi_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Bench for mult_operand_sequencer: three instances (8-bit/lat 1, 8-bit/lat 4,
// 4-bit/lat 1) share the stimulus; sel routes handshakes to one at a time.
module tb_mult_operand_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic       rst;
    logic [7:0] data_in_s;
    logic       in_valid_s;
    logic       dout_ready_s;
    logic [1:0] sel;

    // instance 0: WIDTH=8, MULT_LAT=1, combinational multiplier
    logic       iv0, ir0, ov0, dv0, dl0, dr0;
    logic [7:0] a0, b0, do0;
    logic [15:0] p0;
    // instance 1: WIDTH=8, MULT_LAT=4, product valid only in the 4th cycle
    logic       iv1, ir1, ov1, dv1, dl1, dr1;
    logic [7:0] a1, b1, do1;
    logic [15:0] p1;
    logic [3:0] lat_cnt;
    // instance 2: WIDTH=4, MULT_LAT=1
    logic       iv2, ir2, ov2, dv2, dl2, dr2;
    logic [3:0] a2, b2;
    logic [7:0] do2;
    logic [7:0] p2;

    assign iv0 = in_valid_s && (sel == 2'd0);
    assign iv1 = in_valid_s && (sel == 2'd1);
    assign iv2 = in_valid_s && (sel == 2'd2);
    assign dr0 = dout_ready_s && (sel == 2'd0);
    assign dr1 = dout_ready_s && (sel == 2'd1);
    assign dr2 = dout_ready_s && (sel == 2'd2);

    assign p0 = {8'd0, a0} * {8'd0, b0};
    always @(posedge clk) begin
        if (!ov1) lat_cnt <= 4'd0;
        else      lat_cnt <= lat_cnt + 4'd1;
    end
    assign p1 = (ov1 && lat_cnt == 4'd3) ? ({8'd0, a1} * {8'd0, b1})
                                         : ~({8'd0, a1} * {8'd0, b1});
    assign p2 = {4'd0, a2} * {4'd0, b2};

    mult_operand_sequencer #(.WIDTH(8), .MULT_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in_s), .in_valid(iv0), .in_ready(ir0),
        .op_a(a0), .op_b(b0), .op_valid(ov0), .prod(p0),
        .dout(do0), .dout_valid(dv0), .dout_last(dl0), .dout_ready(dr0));

    mult_operand_sequencer #(.WIDTH(8), .MULT_LAT(4)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in_s), .in_valid(iv1), .in_ready(ir1),
        .op_a(a1), .op_b(b1), .op_valid(ov1), .prod(p1),
        .dout(do1), .dout_valid(dv1), .dout_last(dl1), .dout_ready(dr1));

    mult_operand_sequencer #(.WIDTH(4), .MULT_LAT(1)) u_dut2 (
        .clk(clk), .rst(rst), .data_in(data_in_s), .in_valid(iv2), .in_ready(ir2),
        .op_a(a2), .op_b(b2), .op_valid(ov2), .prod(p2),
        .dout(do2), .dout_valid(dv2), .dout_last(dl2), .dout_ready(dr2));

    // Outputs of the selected instance.
    logic       ir_m, ov_m, dv_m, dl_m;
    logic [7:0] do_m, opa_m, opb_m;
    always_comb begin
        ir_m = ir0; ov_m = ov0; dv_m = dv0; dl_m = dl0; do_m = do0; opa_m = a0; opb_m = b0;
        case (sel)
            2'd1: begin
                ir_m = ir1; ov_m = ov1; dv_m = dv1; dl_m = dl1; do_m = do1; opa_m = a1; opb_m = b1;
            end
            2'd2: begin
                ir_m = ir2; ov_m = ov2; dv_m = dv2; dl_m = dl2; do_m = do2;
                opa_m = {4'd0, a2}; opb_m = {4'd0, b2};
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_opa;
        logic [7:0] exp_opb;
        logic [7:0] exp_lo;
        logic [7:0] exp_hi;
        int         lat;
        int         stall;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ok);
        int t;
        t = 0;
        data_in_s  = d;
        in_valid_s = 1'b1;
        while (!ir_m && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = ir_m;
        @(negedge clk);
        in_valid_s = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit         ok_a, ok_b;
        int         c0, nb, opv, guard, stall_left;
        bit         opab_bad, ir_bad, hold_bad, held_set;
        logic [7:0] bytes[2];
        logic       lasts[2];
        logic [7:0] held;
        sel = v.sel;
        dout_ready_s = 1'b0;
        #1;
        c0 = cyc_cnt;
        send_byte(v.a, ok_a);
        send_byte(v.b, ok_b);
        chk({tag, " accept_a"}, 32'(ok_a), 32'd1);
        chk({tag, " accept_b"}, 32'(ok_b), 32'd1);
        nb = 0; opv = 0; guard = 0; stall_left = v.stall;
        opab_bad = 0; ir_bad = 0; hold_bad = 0; held_set = 0; held = 8'd0;
        bytes[0] = 8'd0; bytes[1] = 8'd0; lasts[0] = 1'b0; lasts[1] = 1'b0;
        while (nb < 2 && guard < 200) begin
            if (ov_m) begin
                opv++;
                if (opa_m !== v.exp_opa || opb_m !== v.exp_opb) opab_bad = 1;
            end
            if (ir_m !== 1'b0) ir_bad = 1;
            if (dv_m && stall_left > 0) begin
                if (!held_set) begin held = do_m; held_set = 1; end
                if (do_m !== held || dl_m !== 1'b0) hold_bad = 1;
                stall_left--;
                dout_ready_s = 1'b0;
            end else begin
                dout_ready_s = 1'b1;
            end
            if (dv_m && dout_ready_s) begin
                bytes[nb] = do_m;
                lasts[nb] = dl_m;
                nb++;
            end
            if (nb == 2) begin
                in_valid_s = 1'b0;
            end else begin
                in_valid_s = 1'($urandom_range(0, 1));
                data_in_s  = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            guard++;
        end
        dout_ready_s = 1'b0;
        chk({tag, " bytes_received"}, 32'(nb), 32'd2);
        chk({tag, " dout_lo"}, 32'(bytes[0]), 32'(v.exp_lo));
        chk({tag, " last_on_lo"}, 32'(lasts[0]), 32'd0);
        chk({tag, " dout_hi"}, 32'(bytes[1]), 32'(v.exp_hi));
        chk({tag, " last_on_hi"}, 32'(lasts[1]), 32'd1);
        chk({tag, " op_valid_cycles"}, 32'(opv), 32'(v.lat));
        chk({tag, " operands_in_mult"}, 32'(opab_bad), 32'd0);
        chk({tag, " in_ready_low_busy"}, 32'(ir_bad), 32'd0);
        if (v.stall > 0) chk({tag, " dout_held_stall"}, 32'(hold_bad), 32'd0);
        chk({tag, " op_cycles"}, 32'(cyc_cnt - c0), 32'(v.lat + 4 + v.stall));
        chk({tag, " in_ready_after_hi"}, 32'(ir_m), 32'd1);
        chk({tag, " dout_valid_after_hi"}, 32'(dv_m), 32'd0);
        chk({tag, " op_a_kept"}, 32'(opa_m), 32'(v.exp_opa));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   t;
        vec_t rv;

        //         sel    a      b      op_a   op_b   lo     hi     lat stall
        vecs[0] = '{2'd0, 8'h07, 8'h09, 8'h07, 8'h09, 8'h3F, 8'h00, 1, 0};
        vecs[1] = '{2'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1, 5};
        vecs[2] = '{2'd0, 8'h00, 8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 1, 0};
        vecs[3] = '{2'd0, 8'h80, 8'h02, 8'h80, 8'h02, 8'h00, 8'h01, 1, 0};
        vecs[4] = '{2'd1, 8'h0C, 8'h0B, 8'h0C, 8'h0B, 8'h84, 8'h00, 4, 0};
        vecs[5] = '{2'd1, 8'hFF, 8'h02, 8'hFF, 8'h02, 8'hFE, 8'h01, 4, 2};
        vecs[6] = '{2'd2, 8'hAB, 8'hC3, 8'h0B, 8'h03, 8'h21, 8'h00, 1, 0};
        vecs[7] = '{2'd2, 8'h0F, 8'hFF, 8'h0F, 8'h0F, 8'hE1, 8'h00, 1, 0};
        vecs[8] = '{2'd2, 8'h07, 8'h0E, 8'h07, 8'h0E, 8'h62, 8'h00, 1, 1};

        rst = 1'b1; data_in_s = 8'd0; in_valid_s = 1'b0; dout_ready_s = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            chk($sformatf("reset%0d in_ready", k), 32'(ir_m), 32'd1);
            chk($sformatf("reset%0d op_valid", k), 32'(ov_m), 32'd0);
            chk($sformatf("reset%0d dout_valid", k), 32'(dv_m), 32'd0);
            chk($sformatf("reset%0d dout_last", k), 32'(dl_m), 32'd0);
            chk($sformatf("reset%0d dout", k), 32'(do_m), 32'd0);
            chk($sformatf("reset%0d op_a", k), 32'(opa_m), 32'd0);
            chk($sformatf("reset%0d op_b", k), 32'(opb_m), 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the low byte is waiting in SEND_LO.
        sel = 2'd0;
        dout_ready_s = 1'b0;
        #1;
        send_byte(8'd5, ok);
        send_byte(8'd6, ok);
        t = 0;
        while (!dv_m && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("midrst reached_send_lo", 32'(dv_m), 32'd1);
        chk("midrst lo_byte_pending", 32'(do_m), 32'd30);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst dout_valid", 32'(dv_m), 32'd0);
        chk("midrst op_valid", 32'(ov_m), 32'd0);
        chk("midrst in_ready", 32'(ir_m), 32'd1);
        dout_ready_s = 1'b1;
        @(negedge clk);
        chk("midrst no_stale_byte", 32'(dv_m), 32'd0);
        dout_ready_s = 1'b0;
        rv = '{2'd0, 8'h02, 8'h03, 8'h02, 8'h03, 8'h06, 8'h00, 1, 0};
        run_vec(rv, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_operand_sequencer.md
Name: mult_operand_sequencer

Overview:
- Byte-wide front/back end for the array multiplier core.
- Captures operand A, then operand B, from an 8-bit input stream with a valid/ready handshake.
- Presents both operands to the multiplier and waits a fixed latency.
- Returns the 16-bit product as two bytes (low first) on an 8-bit valid/ready output.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..8; data_in[7:WIDTH] ignored.
- MULT_LAT, 1, cycles from op_valid rising to prod being sampled; legal range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- data_in  input  8  operand byte.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block accepts data_in this cycle.
- op_a  output  WIDTH  operand A to multiplier.
- op_b  output  WIDTH  operand B to multiplier.
- op_valid  output  1  operands stable; multiplier result pending.
- prod  input  2*WIDTH  product from multiplier.
- dout  output  8  result byte.
- dout_valid  output  1  dout valid.
- dout_last  output  1  dout is the high byte.
- dout_ready  input  1  consumer accepts dout.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=LOAD_A; op_a=0, op_b=0, op_valid=0, dout=0, dout_valid=0, dout_last=0, wait counter=0.
  - in_ready=1 in the first cycle after reset.
  - Reset has priority over every other event, in any state; an in-flight operation is discarded and no partial byte is emitted afterwards.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when dout_valid && dout_ready.
  - in_ready is asserted only in LOAD_A and LOAD_B.
- LOAD_A: on input transfer, op_a<=data_in[WIDTH-1:0], go to LOAD_B.
- LOAD_B:
  - On input transfer: op_b<=data_in[WIDTH-1:0], op_valid<=1, counter<=MULT_LAT-1, go to MULT.
- MULT:
  - op_a/op_b held constant; in_ready=0.
  - If counter==0: latch prod zero-extended to 16 bits into result register, op_valid<=0, go to SEND_LO. Otherwise decrement counter.
  - Total: prod sampled exactly MULT_LAT cycles after the edge that set op_valid.
- SEND_LO:
  - dout=result[7:0], dout_valid=1, dout_last=0.
  - Hold until transfer, then go to SEND_HI.
- SEND_HI:
  - dout=result[15:8], dout_valid=1, dout_last=1.
  - On transfer: dout_valid<=0, go to LOAD_A.
- Output registers: dout and dout_valid are registered and must not change while dout_valid=1 && dout_ready=0.
- Back-to-back operation:
  - in_ready rises the cycle after the high-byte transfer.
  - No combinational path from dout_ready to in_ready.
- Minimum operation time, with no stalls and MULT_LAT=1: 2 load cycles + 1 MULT cycle + 2 send cycles = 5 cycles.
- in_valid while in_ready=0: ignored; no data is dropped from an accepted transfer.
- op_a/op_b keep their last values outside MULT; the downstream block qualifies them with op_valid.
- Arithmetic: no truncation of the product. Upper result bits are 0 when 2*WIDTH<16.

Test Plan:
- Basic: WIDTH=8, MULT_LAT=1, bench multiplier combinational; send 7 then 9 -> op_valid high 1 cycle; dout bytes 0x3F (last=0), 0x00 (last=1).
- Max operands: 0xFF, 0xFF -> bytes 0x01 then 0xFE; dout_last only on the second byte.
- Backpressure and input stall:
  - Hold dout_ready=0 for 5 cycles in SEND_LO -> dout stays 0x01, dout_valid stays 1, in_ready stays 0.
  - Toggle in_valid randomly during MULT and SEND -> result is unaffected.
- Latency: MULT_LAT=4, bench multiplier delayed 4 cycles with garbage before that; operands 12, 11 -> dout 0x84, 0x00.
  - Check that prod is sampled exactly 4 cycles after op_valid rises.
- Narrow width: WIDTH=4; data_in 0xAB, 0xC3 -> op_a=0xB, op_b=0x3; dout 0x21, 0x00.
- Reset mid-operation:
  - Assert rst for 1 cycle in SEND_LO -> next cycle dout_valid=0, op_valid=0, in_ready=1.
  - Next operands 2, 3 -> bytes 0x06, 0x00.
